// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_skid
// Purpose  : Parametrised pipeline-stage register with a 2-entry skid buffer.
//            It carries a control bundle and a data payload between two
//            pipeline stages using a valid/ready handshake.
//            - in_ready_o comes straight from a flop, so downstream
//              backpressure never reaches upstream combinationally.
//            - flush_i squashes every held entry. The control bundle is
//              zeroed in any invalid slot, so an empty slot is a bubble.
// Optional : PIPE_STAGE_PERF_EN adds saturating stall/bubble counters
//            (stall_cnt_o, bubble_cnt_o) and the CNT_W parameter.
// Ports    : clk_i        clock, rising edge
//            rst_i        asynchronous reset, active low
//            flush_i      squash all held entries at the next edge
//            in_valid_i   / in_ready_o / in_ctrl_i / in_data_i    upstream side
//            out_valid_o  / out_ready_i / out_ctrl_o / out_data_o downstream side
//            stall_cnt_o  cycles with out_valid_o=1 and out_ready_i=0 (perf only)
//            bubble_cnt_o cycles with out_valid_o=0 out of reset (perf only)
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_skid #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4
`ifdef PIPE_STAGE_PERF_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [DATA_W-1:0] out_data_o
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
`endif
);

    // Main slot drives the outputs and always holds the older entry.
    logic              main_v;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;

    // Skid slot catches the one entry accepted while main is stalled.
    logic              skid_v;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    // Registered copy of ~skid_v. It resets to 0, so the stage refuses
    // input while it is held in reset.
    logic              ready_q;

    logic              push;
    logic              pop;
    logic              main_free;

    assign in_ready_o  = ready_q;
    assign out_valid_o = main_v;
    assign out_ctrl_o  = main_ctrl;
    assign out_data_o  = main_data;

    assign push      = in_valid_i & ready_q;
    assign pop       = main_v & out_ready_i;
    assign main_free = ~main_v | pop;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            main_v    <= 1'b0;
            main_ctrl <= '0;
            main_data <= '0;
            skid_v    <= 1'b0;
            skid_ctrl <= '0;
            skid_data <= '0;
            ready_q   <= 1'b0;
        end else if (flush_i) begin
            // Squash both slots. A concurrent push is dropped. The data
            // registers keep their contents.
            main_v    <= 1'b0;
            main_ctrl <= '0;
            skid_v    <= 1'b0;
            ready_q   <= 1'b1;
        end else if (main_free) begin
            if (skid_v) begin
                // ready_q was low, so no push can coincide with this refill.
                main_v    <= 1'b1;
                main_ctrl <= skid_ctrl;
                main_data <= skid_data;
                skid_v    <= 1'b0;
            end else begin
                main_v <= push;
                if (push) begin
                    main_ctrl <= in_ctrl_i;
                    main_data <= in_data_i;
                end else begin
                    main_ctrl <= '0;
                end
            end
            ready_q <= 1'b1;
        end else if (push) begin
            // Main is stalled: park the new entry and close the input.
            skid_v    <= 1'b1;
            skid_ctrl <= in_ctrl_i;
            skid_data <= in_data_i;
            ready_q   <= 1'b0;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] bubble_cnt;

    assign stall_cnt_o  = stall_cnt;
    assign bubble_cnt_o = bubble_cnt;

    // These counters saturate, clear only on reset, and ignore flush.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (main_v && !out_ready_i && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (!main_v && (bubble_cnt != CNT_MAX)) begin
                bubble_cnt <= bubble_cnt + 1'b1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised pipeline-stage register, the successor to the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a generic control bundle and data payload between two stages using a valid/ready handshake.
- Includes a 2-entry skid buffer, so downstream backpressure (e.g. cache stall) does not create a combinational ready path upstream.
- Supports flush (squash) with bubble insertion: control bits are zeroed for any invalid slot.

Parameters:
- DATA_W, 32: payload width (ALU result, rs2 data, rd address, etc. concatenated by the instantiating stage).
- CTRL_W, 4: control bundle width (RegWrite, MemtoReg, MemRead, MemWrite, ...). Forced to zero on a bubble.
- CNT_W, 16: performance counter width (used only with PIPE_STAGE_PERF_EN).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- flush_i  in  1  squash all held entries at the next edge.
- in_valid_i  in  1  upstream entry valid.
- in_ready_o  out  1  stage can accept an entry this cycle.
- in_ctrl_i  in  CTRL_W  upstream control bundle.
- in_data_i  in  DATA_W  upstream payload.
- out_valid_o  out  1  output entry valid.
- out_ready_i  in  1  downstream accepts the entry this cycle.
- out_ctrl_o  out  CTRL_W  control bundle; 0 whenever out_valid_o=0.
- out_data_o  out  DATA_W  payload; holds its last value while invalid.
- stall_cnt_o  out  CNT_W  present only with PIPE_STAGE_PERF_EN.
- bubble_cnt_o  out  CNT_W  present only with PIPE_STAGE_PERF_EN.

Behaviour:
- State: main slot {main_v, ctrl, data} drives the outputs; skid slot {skid_v, ctrl, data}. Main always holds the older entry.
- Reset (rst_i=0, asynchronous):
  - main_v=skid_v=0; out_valid_o=0; out_ctrl_o=0; out_data_o=0; skid contents=0; counters=0.
  - in_ready_o=0 while rst_i=0.
- in_ready_o = ~skid_v, driven from a register only. No combinational path from out_ready_i to in_ready_o.
- Define push = in_valid_i & in_ready_o and pop = main_v & out_ready_i.
- Priority at each edge:
  1. flush_i=1: main_v<=0, skid_v<=0, out_ctrl_o<=0. Any concurrent push is dropped; pop is irrelevant. Data registers are unchanged.
  2. main empty or pop, with skid_v=1: main<=skid; skid_v<=0. Push cannot occur because in_ready_o=0.
  3. main empty or pop, with skid_v=0: main_v<=push. If push, main ctrl/data<=input; otherwise ctrl<=0 (bubble).
  4. main full and no pop: if push, skid<=input and skid_v<=1.
- Latency: 1 cycle from accepted input to out_valid_o. Throughput: 1 entry/cycle when out_ready_i=1 continuously.
- Occupancy is never more than 2. Entries are delivered in order and never duplicated or lost, except on flush.
- The output is stable while out_valid_o=1 and out_ready_i=0 (no change to ctrl or data).
- Deasserting in_valid_i with in_ready_o=0 is legal; nothing is captured.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- Defined:
  - stall_cnt_o increments each cycle with out_valid_o=1 & out_ready_i=0.
  - bubble_cnt_o increments each cycle with out_valid_o=0 & rst_i=1.
  - Both counters saturate at 2^CNT_W-1, clear only on reset, and are unaffected by flush_i.
- Undefined: both ports and all counter logic are absent; the rest of the behaviour is identical.

Test Plan:
- Reset then release, out_ready_i=1, stream in_data 0x10,0x11,0x12 with ctrl 0xF -> out_data 0x10,0x11,0x12 on consecutive cycles, each 1 cycle after input; out_ctrl 0xF; in_ready_o=1 throughout.
- out_ready_i=0, push 0xA then 0xB -> out_data=0xA held; in_ready_o=0 after 2nd push. Raise out_ready_i -> 0xA then 0xB delivered, in_ready_o=1 again.
- Two entries held, assert flush_i one cycle with in_valid_i=1 (data 0xC) -> next cycle out_valid_o=0, out_ctrl_o=0, in_ready_o=1; 0xC never appears.
- in_valid_i=0 for 3 cycles mid-stream -> out_valid_o=0 and out_ctrl_o=0 for 3 cycles; out_data_o holds the last value.
- Assert rst_i=0 asynchronously mid-clock with both slots full -> outputs clear immediately (before the next edge); in_ready_o=0 until release.
- With PIPE_STAGE_PERF_EN and CNT_W=4: hold out_ready_i=0 with a valid output for 20 cycles -> stall_cnt_o=15 (saturated); bubble_cnt_o counts idle cycles after reset.
